// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants for the VGA timing generator: default
//                640x480@60 timing, sync polarity encodings, the sync-level
//                record carried through the output pipeline and small
//                helpers for counter widths and colour-bar indexing.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int unsigned c_h_visible = 640;
  localparam int unsigned c_h_front   = 16;
  localparam int unsigned c_h_sync    = 96;
  localparam int unsigned c_h_back    = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int unsigned c_v_visible = 480;
  localparam int unsigned c_v_front   = 10;
  localparam int unsigned c_v_sync    = 2;
  localparam int unsigned c_v_back    = 33;

  // Sync pulse level encodings
  localparam bit c_sync_active_low  = 1'b0;
  localparam bit c_sync_active_high = 1'b1;

  // Number of vertical bars in the built-in test pattern
  localparam int unsigned c_num_bars = 8;

  // Sync levels for one pixel, travelling together through the pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  // Counter width for a given total count; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Bar number for pixel x; pixels past the last full bar stay in bar 7
  function automatic logic [2:0] bar_index(input int unsigned x,
                                           input int unsigned bar_w);
    int unsigned idx;
    idx = x / bar_w;
    return (idx < c_num_bars) ? idx[2:0] : 3'd7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Pixel/colour bundle between a pixel source (master) and the
//                VGA timing generator (slave).
//  Signals     : iPixelEn            pixel-rate enable
//                iRed/iGreen/iBlue   colour for the current oX/oY
//                iPattern            test-pattern select (only when
//                                    VGA_TEST_PATTERN_EN is defined)
//                oX/oY               current pixel coordinates
//                oActive             coordinates inside the visible area
//                oFrameStart         one-clock pulse at frame wrap
//                oRed/oGreen/oBlue   registered colour outputs
//                oHSync/oVSync       registered sync outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 1
);

  logic               iPixelEn;
  logic [COLOR_W-1:0] iRed;
  logic [COLOR_W-1:0] iGreen;
  logic [COLOR_W-1:0] iBlue;
`ifdef VGA_TEST_PATTERN_EN
  logic               iPattern;
`endif
  logic [XW-1:0]      oX;
  logic [YW-1:0]      oY;
  logic               oActive;
  logic               oFrameStart;
  logic [COLOR_W-1:0] oRed;
  logic [COLOR_W-1:0] oGreen;
  logic [COLOR_W-1:0] oBlue;
  logic               oHSync;
  logic               oVSync;

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    output iPattern,
`endif
    output iPixelEn, iRed, iGreen, iBlue,
    input  oX, oY, oActive, oFrameStart,
    input  oRed, oGreen, oBlue, oHSync, oVSync
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    input  iPattern,
`endif
    input  iPixelEn, iRed, iGreen, iBlue,
    output oX, oY, oActive, oFrameStart,
    output oRed, oGreen, oBlue, oHSync, oVSync
  );

endinterface
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_counter
//  Description : Horizontal/vertical pixel counter pair with wrap logic and
//                a one-clock frame-start pulse.
//  Ports       : Clock          system clock, rising edge
//                Reset          asynchronous active-low reset
//                i_en           pixel-rate enable
//                o_x, o_y       current column / line
//                o_frame_start  high for the clock after the enabled edge
//                               that wrapped the counters to (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int XW      = 10,
  parameter int YW      = 10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          i_en,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_frame_start
);

  localparam logic [XW-1:0] c_X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] c_X_ONE  = XW'(1);
  localparam logic [YW-1:0] c_Y_ONE  = YW'(1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_frame_start;
  logic          w_x_wrap;
  logic          w_y_wrap;

  always_comb begin
    w_x_wrap = (r_x == c_X_LAST);
    w_y_wrap = (r_y == c_Y_LAST);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      // The pulse clears on every clock, not only enabled ones, so it is
      // exactly one clock wide even at reduced pixel rates.
      r_frame_start <= 1'b0;
      if (i_en) begin
        if (w_x_wrap) begin
          r_x <= '0;
          if (w_y_wrap) begin
            r_y           <= '0;
            r_frame_start <= 1'b1;
          end else begin
            r_y <= r_y + c_Y_ONE;
          end
        end else begin
          r_x <= r_x + c_X_ONE;
        end
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA timing generator. Counts pixels/lines, decodes the
//                active area and sync windows, and registers colour and sync
//                one enabled pixel behind the coordinates. Colour is forced
//                to zero outside the visible area.
//                Optional feature: define VGA_TEST_PATTERN_EN to add the
//                iPattern input, which replaces input colour with eight
//                vertical colour bars.
//  Ports       : Clock   system clock, rising edge
//                Reset   asynchronous active-low reset
//                bus     vga_timing_gen_if.slave (pixel enable, colour in,
//                        coordinates, active, frame start, VGA outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = c_h_visible,
  parameter int H_FRONT   = c_h_front,
  parameter int H_SYNC    = c_h_sync,
  parameter int H_BACK    = c_h_back,
  parameter int V_VISIBLE = c_v_visible,
  parameter int V_FRONT   = c_v_front,
  parameter int V_SYNC    = c_v_sync,
  parameter int V_BACK    = c_v_back,
  parameter int COLOR_W   = 1,
  parameter bit SYNC_POL  = c_sync_active_low
) (
  input  logic             Clock,
  input  logic             Reset,
  vga_timing_gen_if.slave  bus
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_XW      = cnt_width(c_H_TOTAL);
  localparam int c_YW      = cnt_width(c_V_TOTAL);

  localparam logic [c_XW-1:0] c_X_VIS      = c_XW'(H_VISIBLE);
  localparam logic [c_YW-1:0] c_Y_VIS      = c_YW'(V_VISIBLE);
  localparam logic [c_XW-1:0] c_HS_FIRST   = c_XW'(H_VISIBLE + H_FRONT);
  localparam logic [c_XW-1:0] c_HS_LAST    = c_XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [c_YW-1:0] c_VS_FIRST   = c_YW'(V_VISIBLE + V_FRONT);
  localparam logic [c_YW-1:0] c_VS_LAST    = c_YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam sync_t           c_SYNC_IDLE  = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  logic [c_XW-1:0]    w_x;
  logic [c_YW-1:0]    w_y;
  logic               w_frame_start;
  logic               w_active;
  sync_t              w_sync;
  logic [COLOR_W-1:0] w_red;
  logic [COLOR_W-1:0] w_green;
  logic [COLOR_W-1:0] w_blue;

  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;
  sync_t              r_sync;

  vga_counter #(
    .H_TOTAL (c_H_TOTAL),
    .V_TOTAL (c_V_TOTAL),
    .XW      (c_XW),
    .YW      (c_YW)
  ) u_counter (
    .Clock         (Clock),
    .Reset         (Reset),
    .i_en          (bus.iPixelEn),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_start (w_frame_start)
  );

  // Decode of the current coordinates
  always_comb begin
    w_active     = (w_x < c_X_VIS) && (w_y < c_Y_VIS);
    w_sync.hsync = ((w_x >= c_HS_FIRST) && (w_x <= c_HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    w_sync.vsync = ((w_y >= c_VS_FIRST) && (w_y <= c_VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int c_BAR_W = (H_VISIBLE / c_num_bars > 0) ? H_VISIBLE / c_num_bars : 1;

  logic [2:0] w_bar;

  always_comb begin
    w_bar   = bar_index(int'(w_x), c_BAR_W);
    w_red   = bus.iRed;
    w_green = bus.iGreen;
    w_blue  = bus.iBlue;
    if (bus.iPattern) begin
      // Bar number bits map to R/G/B and are replicated across the channel
      w_red   = {COLOR_W{w_bar[2]}};
      w_green = {COLOR_W{w_bar[1]}};
      w_blue  = {COLOR_W{w_bar[0]}};
    end
  end
`else
  always_comb begin
    w_red   = bus.iRed;
    w_green = bus.iGreen;
    w_blue  = bus.iBlue;
  end
`endif

  // Output stage: colour and sync for the current coordinates appear after
  // the next enabled edge; everything holds while the enable is low.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_sync  <= c_SYNC_IDLE;
    end else if (bus.iPixelEn) begin
      r_red   <= w_active ? w_red   : '0;
      r_green <= w_active ? w_green : '0;
      r_blue  <= w_active ? w_blue  : '0;
      r_sync  <= w_sync;
    end
  end

  assign bus.oX          = w_x;
  assign bus.oY          = w_y;
  assign bus.oActive     = w_active;
  assign bus.oFrameStart = w_frame_start;
  assign bus.oRed        = r_red;
  assign bus.oGreen      = r_green;
  assign bus.oBlue       = r_blue;
  assign bus.oHSync      = r_sync.hsync;
  assign bus.oVSync      = r_sync.vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen in a small
//                configuration (H 8/2/2/2 = 14, V 4/1/1/1 = 7, COLOR_W 2,
//                active-low sync). Directed vector table from reset, then
//                full-frame runs against a behavioural model, a mid-frame
//                asynchronous reset and (with VGA_TEST_PATTERN_EN) the
//                colour-bar pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  vga_timing_gen_if #(.XW(4), .YW(3), .COLOR_W(2)) bus ();

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .COLOR_W   (2),
    .SYNC_POL  (1'b0)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Inputs and expected outputs for one enabled/disabled clock
  typedef struct packed {
    logic       en;
    logic [1:0] r, g, b;
    logic [3:0] x;
    logic [2:0] y;
    logic       act, fs;
    logic [1:0] orr, og, ob;
    logic       hs, vs;
  } vec_t;

  // Output snapshot: {x, y, active, frame_start, r, g, b, hs, vs}
  function automatic logic [16:0] out_bits();
    return {bus.oX, bus.oY, bus.oActive, bus.oFrameStart,
            bus.oRed, bus.oGreen, bus.oBlue, bus.oHSync, bus.oVSync};
  endfunction

  function automatic vec_t mk(logic en, logic [1:0] r, logic [1:0] g, logic [1:0] b,
                              logic [3:0] x, logic [2:0] y, logic act, logic fs,
                              logic [1:0] orr, logic [1:0] og, logic [1:0] ob,
                              logic hs, logic vs);
    vec_t v;
    v = '{en: en, r: r, g: g, b: b, x: x, y: y, act: act, fs: fs,
          orr: orr, og: og, ob: ob, hs: hs, vs: vs};
    return v;
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d act=%b fs=%b rgb=%0d/%0d/%0d hs=%b vs=%b, want x=%0d y=%0d act=%b fs=%b rgb=%0d/%0d/%0d hs=%b vs=%b",
               name, act[16:13], act[12:10], act[9], act[8], act[7:6], act[5:4], act[3:2], act[1], act[0],
               exp[16:13], exp[12:10], exp[9], exp[8], exp[7:6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
    bus.iPixelEn = en;
    bus.iRed     = r;
    bus.iGreen   = g;
    bus.iBlue    = b;
  endtask

  // Reset values at (0,0): active, no pulse, black, both syncs idle-high
  localparam logic [16:0] c_RST_OUT = {4'd0, 3'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1};

  // Holds reset for two clocks, checks reset state, releases at a falling edge
  task automatic apply_reset(input string name);
    Reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0);
`ifdef VGA_TEST_PATTERN_EN
    bus.iPattern = 1'b0;
`endif
    @(negedge Clock);
    @(negedge Clock);
    check(name, out_bits(), c_RST_OUT);
    Reset = 1'b1;
  endtask

  // Runs n clocks against a behavioural model of the timing and checks
  // frame-pulse spacing and sync pulse counts.
  task automatic run_model(input string tag, input int n, input bit toggle,
                           input int exp_first, input int exp_period);
    int mx, my, errs, first, second, hlow, vlow, frames;
    logic en_v, act_prev, efs, ehs, evs;
    logic [1:0] cr, cg, cb, er, eg, eb;
    logic [16:0] exp, got, bad_got, bad_exp;
    mx = 0; my = 0; errs = 0; first = -1; second = -1; hlow = 0; vlow = 0; frames = 0;
    er = 2'd0; eg = 2'd0; eb = 2'd0; ehs = 1'b1; evs = 1'b1;
    bad_got = '0; bad_exp = '0;
    for (int e = 1; e <= n; e++) begin
      en_v = toggle ? (e % 2 == 1) : 1'b1;
      cr = 2'($urandom_range(0, 3));
      cg = 2'($urandom_range(0, 3));
      cb = 2'($urandom_range(0, 3));
      drive(en_v, cr, cg, cb);
      @(posedge Clock);
      efs = 1'b0;
      if (en_v) begin
        act_prev = (mx < 8) && (my < 4);
        er  = act_prev ? cr : 2'd0;
        eg  = act_prev ? cg : 2'd0;
        eb  = act_prev ? cb : 2'd0;
        ehs = !(mx == 10 || mx == 11);
        evs = !(my == 5);
        if (mx == 13) begin
          mx = 0;
          if (my == 6) begin my = 0; efs = 1'b1; frames++; end
          else my++;
        end else begin
          mx++;
        end
      end
      @(negedge Clock);
      exp = {4'(mx), 3'(my), (mx < 8) && (my < 4), efs, er, eg, eb, ehs, evs};
      got = out_bits();
      if (got !== exp) begin
        if (errs == 0) begin bad_got = got; bad_exp = exp; end
        errs++;
      end
      if (en_v && !bus.oHSync) hlow++;
      if (en_v && !bus.oVSync) vlow++;
      if (bus.oFrameStart) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
    end
    if (errs != 0) check({tag, "_model_first_diff"}, bad_got, bad_exp);
    check_int({tag, "_model_errors"}, errs, 0);
    check_int({tag, "_first_pulse"}, first, exp_first);
    check_int({tag, "_pulse_period"}, second - first, exp_period);
    check_int({tag, "_hsync_low_px"}, hlow, 14 * frames);
    check_int({tag, "_vsync_low_px"}, vlow, 14 * frames);
  endtask

  vec_t vecs[17];

  initial begin
    // Directed vectors from reset, each applied for one clock
    vecs[0]  = mk(1, 3, 2, 1,   1, 0, 1, 0, 3, 2, 1, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0,   1, 0, 1, 0, 3, 2, 1, 1, 1);  // hold
    vecs[2]  = mk(1, 1, 1, 1,   2, 0, 1, 0, 1, 1, 1, 1, 1);
    vecs[3]  = mk(1, 2, 0, 3,   3, 0, 1, 0, 2, 0, 3, 1, 1);
    vecs[4]  = mk(1, 3, 3, 3,   4, 0, 1, 0, 3, 3, 3, 1, 1);
    vecs[5]  = mk(1, 3, 3, 3,   5, 0, 1, 0, 3, 3, 3, 1, 1);
    vecs[6]  = mk(1, 3, 3, 3,   6, 0, 1, 0, 3, 3, 3, 1, 1);
    vecs[7]  = mk(1, 3, 3, 3,   7, 0, 1, 0, 3, 3, 3, 1, 1);
    vecs[8]  = mk(1, 3, 3, 3,   8, 0, 0, 0, 3, 3, 3, 1, 1);  // x=7 still visible
    vecs[9]  = mk(1, 3, 3, 3,   9, 0, 0, 0, 0, 0, 0, 1, 1);  // blanking forces 0
    vecs[10] = mk(1, 3, 3, 3,  10, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[11] = mk(1, 3, 3, 3,  11, 0, 0, 0, 0, 0, 0, 0, 1);  // hsync for x=10
    vecs[12] = mk(1, 3, 3, 3,  12, 0, 0, 0, 0, 0, 0, 0, 1);  // hsync for x=11
    vecs[13] = mk(1, 3, 3, 3,  13, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[14] = mk(1, 3, 3, 3,   0, 1, 1, 0, 0, 0, 0, 1, 1);  // line wrap
    vecs[15] = mk(1, 3, 3, 3,   1, 1, 1, 0, 3, 3, 3, 1, 1);
    vecs[16] = mk(0, 1, 1, 1,   1, 1, 1, 0, 3, 3, 3, 1, 1);  // hold

    apply_reset("reset_state");
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].en, vecs[i].r, vecs[i].g, vecs[i].b);
      @(posedge Clock);
      @(negedge Clock);
      check($sformatf("vec%0d", i), out_bits(),
            {vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].fs,
             vecs[i].orr, vecs[i].og, vecs[i].ob, vecs[i].hs, vecs[i].vs});
    end

    // Three full frames at full pixel rate: pulse every 98 clocks
    apply_reset("reset_state_full");
    run_model("full", 3 * 98, 1'b0, 98, 98);

    // Enable toggling each clock: pulse spacing doubles to 196
    apply_reset("reset_state_toggle");
    run_model("toggle", 2 * 2 * 98 + 2, 1'b1, 195, 196);

    // Asynchronous reset mid-frame at (5,2)
    apply_reset("reset_state_async");
    for (int e = 0; e < 33; e++) begin
      drive(1'b1, 2'd3, 2'd3, 2'd3);
      @(posedge Clock);
      @(negedge Clock);
    end
    check("pre_reset_pos", out_bits(), {4'd5, 3'd2, 1'b1, 1'b0, 6'b111111, 1'b1, 1'b1});
    #2 Reset = 1'b0;
    #1 check("async_reset_no_edge", out_bits(), c_RST_OUT);
    @(negedge Clock);
    check("reset_held_over_edge", out_bits(), c_RST_OUT);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("restart_first_edge", out_bits(), {4'd1, 3'd0, 1'b1, 1'b0, 6'b111111, 1'b1, 1'b1});

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: bar width 1, pixel 6 -> bar 6 -> R=3 G=3 B=0
    apply_reset("reset_state_pattern");
    bus.iPattern = 1'b1;
    for (int e = 0; e < 7; e++) begin
      drive(1'b1, 2'd1, 2'd2, 2'd1);
      @(posedge Clock);
      @(negedge Clock);
    end
    check("pattern_bar6", out_bits(), {4'd7, 3'd0, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 1'b1, 1'b1});
    bus.iPattern = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
